i2c_reg_arbiter: RTL and testbench
==================================

Name: i2c_reg_arbiter

Overview:
- Shares one byte-level I2C engine (the i2c_master datapath) between NUM_REQ register-access requesters.
- Arbitrates round-robin and sequences each request into the engine command stream:
  - register write: START, addr+W, reg, data, STOP.
  - register read: START, addr+W, reg, repeated START, addr+R, READ, STOP.
- Returns read data and NACK/timeout status to the granted requester.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
TIMEOUT_CYCLES, 1000000, max sysclk cycles waiting for eng_done per command (greater than 0)

Ports:
sysclk  in  1  system clock, 100 MHz
reset  in  1  synchronous, active-high
req_valid  in  NUM_REQ  request pending, held until req_ready
req_rw  in  NUM_REQ  1 = register read, 0 = register write
req_addr  in  7*NUM_REQ  7-bit slave address; slice i belongs to requester i
req_reg  in  8*NUM_REQ  register pointer byte
req_wdata  in  8*NUM_REQ  write data byte
req_ready  out  NUM_REQ  one-cycle accept pulse to the granted requester
resp_valid  out  NUM_REQ  one-cycle completion pulse to the granted requester
resp_rdata  out  8  read byte, valid with resp_valid; 0 for writes
resp_nack  out  1  slave NACKed an address or data byte
resp_timeout  out  1  engine did not complete a command
busy  out  1  transaction in progress
eng_cmd_valid  out  1  command offered to engine
eng_cmd  out  2  0 = START, 1 = WRITE, 2 = READ, 3 = STOP
eng_wdata  out  8  byte for WRITE
eng_rd_nack  out  1  master NACKs after READ; always 1 in this block
eng_cmd_ready  in  1  engine accepts command
eng_done  in  1  one-cycle pulse: command finished
eng_ack  in  1  slave ACK for last WRITE, valid with eng_done
eng_rdata  in  8  read byte, valid with eng_done

Behaviour:
- Reset: state IDLE; all outputs 0; last_grant = NUM_REQ-1, so requester 0 has first priority. A reset mid-transaction drops the transaction: no STOP and no response. The engine is reset by the same reset.
- IDLE, when any req_valid is high:
  - Grant g = first index after last_grant, wrapping, with req_valid[g] set.
  - Latch rw, addr, reg and wdata for g.
  - Pulse req_ready[g] for that one cycle; set last_grant = g.
  - Raise busy; go to ISSUE with the first step.
- Step list:
  - write: START, WRITE {addr,0}, WRITE reg, WRITE wdata, STOP.
  - read: START, WRITE {addr,0}, WRITE reg, START, WRITE {addr,1}, READ, STOP.
- ISSUE: hold eng_cmd_valid with eng_cmd/eng_wdata stable until eng_cmd_ready is high in the same cycle, then go to WAIT. eng_cmd_valid drops the cycle after the handshake.
- WAIT: count cycles from 0; on eng_done:
  - WRITE with eng_ack = 0: set nack_flag, next step = STOP.
  - READ: capture eng_rdata.
  - STOP: go to RESP.
  - Otherwise: advance to the next step, back to ISSUE.
- Timeout:
  - If the WAIT count reaches TIMEOUT_CYCLES-1 without eng_done: set timeout_flag, next step = STOP.
  - A timeout while waiting on STOP goes straight to RESP.
  - ISSUE has no timeout.
- RESP, one cycle: pulse resp_valid[g]; drive resp_nack/resp_timeout from the flags and resp_rdata (0 for writes). Clear the flags and go to IDLE.
- A request that is already high is granted in the cycle after RESP at the earliest. busy is high from the grant cycle through the RESP cycle inclusive.
- eng_done outside WAIT is ignored. Changes on req_* after grant are ignored.
- Minimum latency, with the engine responding immediately: each step takes 2 cycles (ISSUE + WAIT).

Test Plan:
- Req0 write, addr 0x50, reg 0x10, data 0xA5, engine always acks -> commands START, W 0xA0, W 0x10, W 0xA5, STOP -> resp_valid[0] with nack = 0, timeout = 0, rdata = 0x00.
- Req1 read, addr 0x68, reg 0x75, engine returns 0x68 -> START, W 0xD0, W 0x75, START, W 0xD1, READ (eng_rd_nack = 1), STOP -> resp_valid[1] with rdata = 0x68.
- Req0 write, eng_ack = 0 on the address byte -> the next command is STOP (no reg/data writes) -> resp_nack = 1.
- Both req_valid held continuously over 4 transactions -> grant order 0, 1, 0, 1; req_ready is never asserted while busy.
- TIMEOUT_CYCLES = 16, eng_done withheld after W 0xA0 -> STOP issued 16 cycles after the handshake -> resp_timeout = 1; the next request is served normally.
- Assert reset during the READ step -> next cycle all outputs 0, busy = 0; a new req1 issues START with no leftover state.

Source files
------------

// File: rtl/i2c_reg_arbiter.sv
// ---------------------------------------------------------------------------
// i2c_reg_arbiter
//
// Shares one byte-level I2C engine between NUM_REQ register-access
// requesters. Requests are granted round-robin and expanded into the
// engine command stream:
//   write : START, WRITE {addr,0}, WRITE reg, WRITE data, STOP
//   read  : START, WRITE {addr,0}, WRITE reg, START, WRITE {addr,1}, READ, STOP
// Read data and NACK/timeout status go back to the granted requester.
//
// Ports
//   sysclk, reset            clock, synchronous active-high reset
//   req_valid/rw/addr/reg/wdata   per-requester request (packed slices)
//   req_ready                one-cycle accept pulse to the granted requester
//   resp_valid/rdata/nack/timeout completion pulse and status
//   busy                     high from the grant cycle through the response cycle
//   eng_cmd_valid/cmd/wdata/rd_nack, eng_cmd_ready   command channel to engine
//   eng_done/ack/rdata       command completion from engine
//
// state  | meaning
// -------+----------------------------------------------------------------
// IDLE   | no transaction; pick the next requester round-robin
// ISSUE  | eng_cmd_valid held until eng_cmd_ready
// WAIT   | command accepted; wait for eng_done or the timeout counter
// RESP   | one-cycle response pulse to the owner, flags cleared
// ---------------------------------------------------------------------------
module i2c_reg_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                   sysclk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ-1:0]     req_rw,
  input  logic [7*NUM_REQ-1:0]   req_addr,
  input  logic [8*NUM_REQ-1:0]   req_reg,
  input  logic [8*NUM_REQ-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [NUM_REQ-1:0]     resp_valid,
  output logic [7:0]             resp_rdata,
  output logic                   resp_nack,
  output logic                   resp_timeout,
  output logic                   busy,
  output logic                   eng_cmd_valid,
  output logic [1:0]             eng_cmd,
  output logic [7:0]             eng_wdata,
  output logic                   eng_rd_nack,
  input  logic                   eng_cmd_ready,
  input  logic                   eng_done,
  input  logic                   eng_ack,
  input  logic [7:0]             eng_rdata
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  // Down-counter load: reaching zero corresponds to an up-count of TIMEOUT_CYCLES-1.
  localparam logic [TW-1:0] TO_LOAD = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] CMD_START = 2'd0;
  localparam logic [1:0] CMD_WRITE = 2'd1;
  localparam logic [1:0] CMD_READ  = 2'd2;
  localparam logic [1:0] CMD_STOP  = 2'd3;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_t;

  typedef enum logic [2:0] {
    SP_START1, SP_ADDRW, SP_REG, SP_DATA,
    SP_START2, SP_ADDRR, SP_READ, SP_STOP
  } step_t;

  state_t          state;
  step_t           step;
  logic [GW-1:0]   last_grant;
  logic [GW-1:0]   owner;
  logic            rw_q;
  logic [6:0]      addr_q;
  logic [7:0]      reg_q;
  logic [7:0]      wdata_q;
  logic [7:0]      rdata_q;
  logic            nack_flag;
  logic            timeout_flag;
  logic [TW-1:0]   to_cnt;

  function automatic logic [1:0] cmd_of(step_t s);
    case (s)
      SP_START1, SP_START2: cmd_of = CMD_START;
      SP_READ:              cmd_of = CMD_READ;
      SP_STOP:              cmd_of = CMD_STOP;
      default:              cmd_of = CMD_WRITE;
    endcase
  endfunction

  function automatic logic [7:0] byte_of(step_t s, logic [6:0] a, logic [7:0] r,
                                         logic [7:0] d);
    case (s)
      SP_ADDRW: byte_of = {a, 1'b0};
      SP_ADDRR: byte_of = {a, 1'b1};
      SP_REG:   byte_of = r;
      SP_DATA:  byte_of = d;
      default:  byte_of = 8'h00;
    endcase
  endfunction

  // Reads branch off after the register pointer into a repeated START.
  function automatic step_t step_after(step_t s, logic rd);
    case (s)
      SP_START1: step_after = SP_ADDRW;
      SP_ADDRW:  step_after = SP_REG;
      SP_REG:    step_after = rd ? SP_START2 : SP_DATA;
      SP_START2: step_after = SP_ADDRR;
      SP_ADDRR:  step_after = SP_READ;
      default:   step_after = SP_STOP;
    endcase
  endfunction

  // Unpacked views of the per-requester request fields.
  logic [6:0] addr_arr  [NUM_REQ];
  logic [7:0] reg_arr   [NUM_REQ];
  logic [7:0] wdata_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign addr_arr[i]  = req_addr[7*i +: 7];
    assign reg_arr[i]   = req_reg[8*i +: 8];
    assign wdata_arr[i] = req_wdata[8*i +: 8];
  end

  // Round-robin search starting one past the last grant.
  logic            grant_found;
  logic [GW-1:0]   grant_idx;
  logic [GW-1:0]   cand_idx;
  int              cand;

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    cand_idx    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = int'(last_grant) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = GW'(cand);
      if (!grant_found && req_valid[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  logic [NUM_REQ-1:0] grant_onehot;
  logic [NUM_REQ-1:0] owner_onehot;
  assign grant_onehot = NUM_REQ'(1) << grant_idx;
  assign owner_onehot = NUM_REQ'(1) << owner;

  // WAIT exit: a NACKed write or a timeout both short-circuit to STOP.
  logic   to_expired;
  logic   wr_nacked;
  step_t  wait_next;

  always_comb begin
    to_expired = (to_cnt == '0);
    wr_nacked  = (cmd_of(step) == CMD_WRITE) && !eng_ack;
    wait_next  = SP_STOP;
    if (eng_done && !wr_nacked) wait_next = step_after(step, rw_q);
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state         <= ST_IDLE;
      step          <= SP_START1;
      last_grant    <= GW'(NUM_REQ - 1);
      owner         <= '0;
      rw_q          <= 1'b0;
      addr_q        <= '0;
      reg_q         <= '0;
      wdata_q       <= '0;
      rdata_q       <= '0;
      nack_flag     <= 1'b0;
      timeout_flag  <= 1'b0;
      to_cnt        <= '0;
      req_ready     <= '0;
      resp_valid    <= '0;
      resp_rdata    <= '0;
      resp_nack     <= 1'b0;
      resp_timeout  <= 1'b0;
      busy          <= 1'b0;
      eng_cmd_valid <= 1'b0;
      eng_cmd       <= CMD_START;
      eng_wdata     <= '0;
      eng_rd_nack   <= 1'b0;
    end else begin
      req_ready   <= '0;
      resp_valid  <= '0;
      // The master always NACKs its single read byte.
      eng_rd_nack <= 1'b1;

      unique case (state)
        ST_IDLE: begin
          if (grant_found) begin
            req_ready     <= grant_onehot;
            last_grant    <= grant_idx;
            owner         <= grant_idx;
            rw_q          <= req_rw[grant_idx];
            addr_q        <= addr_arr[grant_idx];
            reg_q         <= reg_arr[grant_idx];
            wdata_q       <= wdata_arr[grant_idx];
            busy          <= 1'b1;
            step          <= SP_START1;
            eng_cmd       <= CMD_START;
            eng_wdata     <= 8'h00;
            eng_cmd_valid <= 1'b1;
            state         <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          if (eng_cmd_ready) begin
            eng_cmd_valid <= 1'b0;
            to_cnt        <= TO_LOAD;
            state         <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (eng_done || to_expired) begin
            if (step == SP_STOP) begin
              // A STOP that never completes still ends the transaction.
              resp_valid   <= owner_onehot;
              resp_nack    <= nack_flag;
              resp_timeout <= timeout_flag | ~eng_done;
              resp_rdata   <= rw_q ? rdata_q : 8'h00;
              state        <= ST_RESP;
            end else begin
              if (eng_done) begin
                if (step == SP_READ) rdata_q <= eng_rdata;
                if (wr_nacked) nack_flag <= 1'b1;
              end else begin
                timeout_flag <= 1'b1;
              end
              step          <= wait_next;
              eng_cmd       <= cmd_of(wait_next);
              eng_wdata     <= byte_of(wait_next, addr_q, reg_q, wdata_q);
              eng_cmd_valid <= 1'b1;
              state         <= ST_ISSUE;
            end
          end else begin
            to_cnt <= to_cnt - TW'(1);
          end
        end

        ST_RESP: begin
          resp_rdata   <= 8'h00;
          resp_nack    <= 1'b0;
          resp_timeout <= 1'b0;
          nack_flag    <= 1'b0;
          timeout_flag <= 1'b0;
          rdata_q      <= 8'h00;
          busy         <= 1'b0;
          state        <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_reg_arbiter.sv
// ---------------------------------------------------------------------------
// tb_i2c_reg_arbiter
//
// Directed bench for i2c_reg_arbiter (NUM_REQ = 2, TIMEOUT_CYCLES = 16).
// A small engine model accepts commands, logs them and answers with
// eng_done one cycle after acceptance unless told to withhold it or to
// NACK a given byte. Expected command streams and responses are written
// out by hand per step.
// ---------------------------------------------------------------------------
module tb_i2c_reg_arbiter;

  logic        sysclk = 1'b0;
  logic        reset  = 1'b1;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_rw    = '0;
  logic [13:0] req_addr  = '0;
  logic [15:0] req_reg   = '0;
  logic [15:0] req_wdata = '0;
  logic [1:0]  req_ready;
  logic [1:0]  resp_valid;
  logic [7:0]  resp_rdata;
  logic        resp_nack;
  logic        resp_timeout;
  logic        busy;
  logic        eng_cmd_valid;
  logic [1:0]  eng_cmd;
  logic [7:0]  eng_wdata;
  logic        eng_rd_nack;
  logic        eng_cmd_ready = 1'b1;
  logic        eng_done  = 1'b0;
  logic        eng_ack   = 1'b0;
  logic [7:0]  eng_rdata = '0;

  i2c_reg_arbiter #(.NUM_REQ(2), .TIMEOUT_CYCLES(16)) dut (
    .sysclk(sysclk), .reset(reset),
    .req_valid(req_valid), .req_rw(req_rw), .req_addr(req_addr),
    .req_reg(req_reg), .req_wdata(req_wdata), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_nack(resp_nack),
    .resp_timeout(resp_timeout), .busy(busy),
    .eng_cmd_valid(eng_cmd_valid), .eng_cmd(eng_cmd), .eng_wdata(eng_wdata),
    .eng_rd_nack(eng_rd_nack), .eng_cmd_ready(eng_cmd_ready),
    .eng_done(eng_done), .eng_ack(eng_ack), .eng_rdata(eng_rdata)
  );

  always #5 sysclk = ~sysclk;

  int errors = 0;
  int checks = 0;

  // Engine behaviour knobs (written by the stimulus block only).
  int          nack_byte = -1;
  int          hold_byte = -1;
  logic        hold_read = 1'b0;
  logic [7:0]  rd_val    = 8'h00;

  // Logs (written by the monitor only).
  logic [1:0]  log_cmd [128];
  logic [7:0]  log_wd  [128];
  logic        log_rn  [128];
  int          log_gap [128];
  int          log_n = 0;
  int          resp_ix [32];
  logic [7:0]  resp_rd [32];
  logic        resp_nk [32];
  logic        resp_to [32];
  int          resp_n = 0;
  int          gnt_ix  [32];
  int          gnt_n = 0;
  int          overlap = 0;
  int          busy_viol = 0;
  logic        outstanding = 1'b0;
  int          cyc = 0;
  int          last_hs = 0;
  logic        hs;
  logic [1:0]  hs_cmd;
  logic [7:0]  hs_wd;
  logic        withhold;

  // Monitor + engine model: sample at negedge, answer just after posedge.
  always begin
    @(negedge sysclk);
    cyc++;
    hs     = eng_cmd_valid && eng_cmd_ready && !reset;
    hs_cmd = eng_cmd;
    hs_wd  = eng_wdata;
    if (hs && log_n < 128) begin
      log_cmd[log_n] = eng_cmd;
      log_wd[log_n]  = eng_wdata;
      log_rn[log_n]  = eng_rd_nack;
      log_gap[log_n] = cyc - last_hs;
      last_hs = cyc;
      log_n++;
    end
    if (reset) begin
      outstanding = 1'b0;
    end else begin
      if (|req_ready && gnt_n < 32) begin
        if (outstanding) overlap++;
        outstanding = 1'b1;
        gnt_ix[gnt_n] = req_ready[1] ? 1 : 0;
        gnt_n++;
      end
      if (|resp_valid && resp_n < 32) begin
        resp_ix[resp_n] = resp_valid[1] ? 1 : 0;
        resp_rd[resp_n] = resp_rdata;
        resp_nk[resp_n] = resp_nack;
        resp_to[resp_n] = resp_timeout;
        resp_n++;
        outstanding = 1'b0;
      end
      if ((eng_cmd_valid || |resp_valid || |req_ready) && !busy) busy_viol++;
    end
    @(posedge sysclk);
    #1;
    eng_done  = 1'b0;
    eng_ack   = 1'b0;
    eng_rdata = 8'h00;
    if (hs && !reset) begin
      withhold = (hs_cmd == 2'd1 && int'(hs_wd) == hold_byte) ||
                 (hs_cmd == 2'd2 && hold_read);
      if (!withhold) begin
        eng_done = 1'b1;
        eng_ack  = !(hs_cmd == 2'd1 && int'(hs_wd) == nack_byte);
        if (hs_cmd == 2'd2) eng_rdata = rd_val;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  logic [9:0] exp_seq [8];

  function automatic logic [9:0] c_w(input logic [7:0] b);
    return {2'd1, b};
  endfunction

  localparam logic [9:0] C_START = {2'd0, 8'h00};
  localparam logic [9:0] C_READ  = {2'd2, 8'h00};
  localparam logic [9:0] C_STOP  = {2'd3, 8'h00};

  task automatic chk_seq(input string tag, input int base, input int n);
    chk({tag, " count"}, log_n - base, n);
    for (int i = 0; i < n; i++)
      chk($sformatf("%s cmd%0d", tag, i),
          {log_cmd[base+i], (log_cmd[base+i] == 2'd1) ? log_wd[base+i] : 8'h00},
          exp_seq[i]);
  endtask

  task automatic issue_req(input int i, input logic rw, input logic [6:0] a,
                           input logic [7:0] r, input logic [7:0] d);
    logic seen;
    seen = 1'b0;
    req_rw[i]          = rw;
    req_addr[i*7 +: 7] = a;
    req_reg[i*8 +: 8]  = r;
    req_wdata[i*8 +: 8] = d;
    req_valid[i]       = 1'b1;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge sysclk);
      if (req_ready[i]) seen = 1'b1;
    end
    req_valid[i] = 1'b0;
    chk($sformatf("req_ready%0d seen", i), seen, 1);
  endtask

  task automatic wait_resps(input int target, input int budget);
    for (int k = 0; k < budget && resp_n < target; k++) @(negedge sysclk);
    chk("response arrived", (resp_n >= target), 1);
  endtask

  task automatic chk_resp(input string tag, input int idx, input int ix,
                          input logic [7:0] rd, input logic nk, input logic to);
    chk({tag, " idx"},     resp_ix[idx], ix);
    chk({tag, " rdata"},   resp_rd[idx], rd);
    chk({tag, " nack"},    resp_nk[idx], nk);
    chk({tag, " timeout"}, resp_to[idx], to);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int b, r, g;
  logic found;

  initial begin
    // Reset state
    repeat (3) @(negedge sysclk);
    chk("reset outputs", {req_ready, resp_valid, resp_rdata, resp_nack, resp_timeout,
                          eng_cmd_valid, eng_cmd, eng_wdata, eng_rd_nack}, 0);
    chk("reset busy", busy, 0);
    reset = 1'b0;
    @(negedge sysclk);

    // Req0 write 0x50/0x10/0xA5; START held while engine not ready
    eng_cmd_ready = 1'b0;
    b = log_n; r = resp_n;
    issue_req(0, 1'b0, 7'h50, 8'h10, 8'hA5);
    repeat (2) @(negedge sysclk);
    chk("issue holds valid", eng_cmd_valid, 1);
    chk("issue holds START", eng_cmd, 0);
    chk("busy during txn", busy, 1);
    @(posedge sysclk);
    #1 eng_cmd_ready = 1'b1;
    wait_resps(r + 1, 200);
    exp_seq[0] = C_START; exp_seq[1] = c_w(8'hA0); exp_seq[2] = c_w(8'h10);
    exp_seq[3] = c_w(8'hA5); exp_seq[4] = C_STOP;
    chk_seq("write", b, 5);
    for (int i = 1; i < 5; i++) chk($sformatf("write step%0d latency", i), log_gap[b+i], 2);
    chk_resp("write resp", r, 0, 8'h00, 1'b0, 1'b0);
    repeat (2) @(negedge sysclk);
    chk("busy idle after resp", busy, 0);

    // Req1 read 0x68/0x75, engine returns 0x68
    rd_val = 8'h68;
    b = log_n; r = resp_n;
    issue_req(1, 1'b1, 7'h68, 8'h75, 8'h00);
    wait_resps(r + 1, 200);
    exp_seq[0] = C_START; exp_seq[1] = c_w(8'hD0); exp_seq[2] = c_w(8'h75);
    exp_seq[3] = C_START; exp_seq[4] = c_w(8'hD1); exp_seq[5] = C_READ;
    exp_seq[6] = C_STOP;
    chk_seq("read", b, 7);
    chk("read rd_nack", log_rn[b+5], 1);
    chk_resp("read resp", r, 1, 8'h68, 1'b0, 1'b0);

    // Both requesters held over four transactions
    g = gnt_n; r = resp_n;
    req_rw = 2'b00;
    req_addr = {7'h51, 7'h50};
    req_reg = {8'h02, 8'h01};
    req_wdata = {8'h22, 8'h11};
    req_valid = 2'b11;
    for (int k = 0; k < 400 && gnt_n < g + 4; k++) @(negedge sysclk);
    req_valid = 2'b00;
    wait_resps(r + 4, 400);
    chk("rr grant 1st", gnt_ix[g],   0);
    chk("rr grant 2nd", gnt_ix[g+1], 1);
    chk("rr grant 3rd", gnt_ix[g+2], 0);
    chk("rr grant 4th", gnt_ix[g+3], 1);
    chk("rr resp 1st", resp_ix[r],   0);
    chk("rr resp 4th", resp_ix[r+3], 1);
    chk("ready while busy", overlap, 0);
    chk("busy coverage", busy_viol, 0);
    repeat (3) @(negedge sysclk);
    chk("no extra grant", gnt_n, g + 4);

    // Address NACK -> STOP directly
    nack_byte = 8'hA0;
    b = log_n; r = resp_n;
    issue_req(0, 1'b0, 7'h50, 8'h22, 8'h33);
    wait_resps(r + 1, 200);
    exp_seq[0] = C_START; exp_seq[1] = c_w(8'hA0); exp_seq[2] = C_STOP;
    chk_seq("nack", b, 3);
    chk_resp("nack resp", r, 0, 8'h00, 1'b1, 1'b0);
    nack_byte = -1;

    // Timeout: done withheld after W 0xA0; STOP valid 16 clocks after acceptance
    hold_byte = 8'hA0;
    b = log_n; r = resp_n;
    issue_req(0, 1'b0, 7'h50, 8'h44, 8'h55);
    wait_resps(r + 1, 200);
    exp_seq[0] = C_START; exp_seq[1] = c_w(8'hA0); exp_seq[2] = C_STOP;
    chk_seq("timeout", b, 3);
    chk("timeout STOP gap", log_gap[b+2], 17);
    chk_resp("timeout resp", r, 0, 8'h00, 1'b0, 1'b1);
    hold_byte = -1;
    b = log_n; r = resp_n;
    issue_req(1, 1'b0, 7'h20, 8'h30, 8'h40);
    wait_resps(r + 1, 200);
    exp_seq[0] = C_START; exp_seq[1] = c_w(8'h40); exp_seq[2] = c_w(8'h30);
    exp_seq[3] = c_w(8'h40); exp_seq[4] = C_STOP;
    chk_seq("after timeout", b, 5);
    chk_resp("after timeout resp", r, 1, 8'h00, 1'b0, 1'b0);

    // Reset during the READ step
    hold_read = 1'b1;
    b = log_n; r = resp_n;
    issue_req(1, 1'b1, 7'h3C, 8'h05, 8'h00);
    found = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      @(negedge sysclk);
      if (log_n > b && log_cmd[log_n-1] == 2'd2) found = 1'b1;
    end
    chk("reached READ", found, 1);
    repeat (2) @(negedge sysclk);
    chk("busy before reset", busy, 1);
    reset = 1'b1;
    @(negedge sysclk);
    chk("mid reset outputs", {req_ready, resp_valid, resp_rdata, resp_nack, resp_timeout,
                              eng_cmd_valid, eng_cmd, eng_wdata, eng_rd_nack}, 0);
    chk("mid reset busy", busy, 0);
    @(negedge sysclk);
    reset = 1'b0;
    hold_read = 1'b0;
    rd_val = 8'h99;
    repeat (3) @(negedge sysclk);
    chk("no resp for dropped txn", resp_n, r);
    b = log_n;
    issue_req(1, 1'b1, 7'h3C, 8'h05, 8'h00);
    wait_resps(r + 1, 200);
    exp_seq[0] = C_START; exp_seq[1] = c_w(8'h78); exp_seq[2] = c_w(8'h05);
    exp_seq[3] = C_START; exp_seq[4] = c_w(8'h79); exp_seq[5] = C_READ;
    exp_seq[6] = C_STOP;
    chk_seq("post reset read", b, 7);
    chk_resp("post reset resp", r, 1, 8'h99, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
